// File: rtl/cpu_pkg.sv
// Shared core definitions for the multiply/divide unit.
//   muldiv_op_t    : operation select driven from decode (Op port encoding)
//   muldiv_state_t : iterative unit control states
//   XLEN           : architectural register width
//   REG_IDX_W      : register-file index width
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MULHU = 2'b01,
        DIVU  = 2'b10,
        REMU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide unit, one result bit per clock.
// Sits beside the ALU on the register-file read operands and drives the
// register-file write port on completion.
//
// Ports:
//   Clk, Rst         clock (rising edge), synchronous active-high reset
//   Start            one-cycle request, accepted only while idle
//   Op               00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   OperandA/B       multiplicand/dividend, multiplier/divisor
//   DestRegister     write-back register index, captured with Start
//   Busy             high while an operation is running or completing
//   Done             one-cycle completion pulse
//   Result           registered result, held until the next completion
//   RegWrite         write-back strobe (suppressed for r0)
//   WriteRegister    captured DestRegister
//   WriteData        same as Result
module iter_muldiv
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int ITER  = WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [1:0]           Op,
    input  logic [WIDTH-1:0]     OperandA,
    input  logic [WIDTH-1:0]     OperandB,
    input  logic [REG_IDX_W-1:0] DestRegister,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     Result,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] WriteRegister,
    output logic [WIDTH-1:0]     WriteData
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    muldiv_state_t        state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    muldiv_op_t           op_q;
    logic [WIDTH-1:0]     b_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [WIDTH-1:0]     result_q;

    // Shared shift register: {hi,lo} is the product accumulator for
    // multiply and {R,Q} for divide (hi = partial remainder, lo = quotient).
    logic [WIDTH-1:0]     hi, lo;
    logic [WIDTH-1:0]     hi_nxt, lo_nxt;
    logic [WIDTH-1:0]     res_nxt;

    logic                 is_div;
    logic [WIDTH:0]       mul_sum;   // 33-bit add, carry kept
    logic [WIDTH:0]       r_sh;      // 33-bit partial remainder after shift
    logic [WIDTH+1:0]     diff;      // extra MSB acts as the borrow
    logic                 ge;
    logic                 unused_diff_bit;

    assign is_div = op_q[1];

    // Multiply step: conditional add of B, then shift {carry,hi,lo} right.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);

    // Divide step: shift {R,Q} left, trial-subtract B, restore on borrow.
    // The remainder is always below B, so after the step it fits WIDTH bits.
    assign r_sh            = {hi, lo[WIDTH-1]};
    assign diff            = {1'b0, r_sh} - {2'b00, b_q};
    assign ge              = ~diff[WIDTH+1];
    assign unused_diff_bit = diff[WIDTH];

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            hi_nxt = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        res_nxt = lo_nxt;
        case (op_q)
            MUL:   res_nxt = lo_nxt;
            MULHU: res_nxt = hi_nxt;
            DIVU:  res_nxt = lo_nxt;
            REMU:  res_nxt = hi_nxt;
            default: res_nxt = lo_nxt;
        endcase
    end

    // Control: next state and decoded status outputs
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registers: operand capture on accept, one iteration per RUN edge,
    // result captured on the final iteration.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= MUL;
            b_q      <= '0;
            dest_q   <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && Start) begin
                op_q   <= muldiv_op_t'(Op);
                b_q    <= OperandB;
                dest_q <= DestRegister;
                hi     <= '0;
                lo     <= OperandA;
                cnt    <= '0;
            end else if (state == RUN) begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) result_q <= res_nxt;
            end
        end
    end

    assign Result        = result_q;
    assign WriteData     = result_q;
    assign WriteRegister = dest_q;
    assign RegWrite      = Done && (dest_q != '0);

endmodule
